// File: rtl/mmc1x_pkg.sv
// Shared constants and encodings for the mmc1x mapper: register indices,
// control reset value and the mirroring / PRG-mode encodings of ctrl.
package mmc1x_pkg;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_CHR0 = 2'd1;
  localparam logic [1:0] REG_CHR1 = 2'd2;
  localparam logic [1:0] REG_PRG  = 2'd3;

  localparam logic [4:0] CTRL_RESET = 5'h0C;

  typedef enum logic [1:0] {
    MIR_ONE_LO = 2'd0,
    MIR_ONE_HI = 2'd1,
    MIR_VERT   = 2'd2,
    MIR_HORZ   = 2'd3
  } mirror_e;

  typedef enum logic [1:0] {
    PRG_32K_A  = 2'd0,
    PRG_32K_B  = 2'd1,
    PRG_FIX_LO = 2'd2,
    PRG_FIX_HI = 2'd3
  } prg_mode_e;

endpackage

// File: rtl/mmc1x_serial.sv
// Serial load port: consecutive-write filter, 4-bit shift register and write
// counter. Commit and port-reset strobes are combinational for the current edge.
module mmc1x_serial
  import mmc1x_pkg::*;
#(
  parameter int IGNORE_CONSEC = 1
) (
  input  logic       i_m2,
  input  logic       i_res,
  input  logic       i_wr,
  input  logic       i_a14,
  input  logic       i_a13,
  input  logic       i_d0,
  input  logic       i_d7,
  output logic       o_commit,
  output logic [1:0] o_commit_idx,
  output logic [4:0] o_commit_val,
  output logic       o_d7_reset
);

  logic [3:0] r_sr;
  logic [2:0] r_cnt;
  logic       r_last_wr;
  logic       w_accept;

  // A write directly following another write (6502 RMW dummy write) is dropped.
  assign w_accept     = i_wr & ~((IGNORE_CONSEC != 0) & r_last_wr);
  assign o_d7_reset   = w_accept & i_d7;
  assign o_commit     = w_accept & ~i_d7 & (r_cnt == 3'd4);
  assign o_commit_idx = {i_a14, i_a13};
  assign o_commit_val = {i_d0, r_sr};

  always_ff @(negedge i_m2 or posedge i_res) begin
    if (i_res) begin
      r_sr      <= 4'd0;
      r_cnt     <= 3'd0;
      r_last_wr <= 1'b0;
    end else begin
      r_last_wr <= i_wr;
      if (w_accept) begin
        if (i_d7 || (r_cnt == 3'd4)) begin
          r_sr  <= 4'd0;
          r_cnt <= 3'd0;
        end else begin
          r_sr[r_cnt[1:0]] <= i_d0;
          r_cnt            <= r_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/mmc1x.sv
// mmc1x mapper top: ctrl/chr0/chr1/prg register file updated from the serial
// port on the M2 falling edge, plus combinational PRG/CHR/WRAM/CIRAM mapping.
module mmc1x
  import mmc1x_pkg::*;
#(
  parameter int PRG_AW        = 18,
  parameter int CHR_AW        = 17,
  parameter int SXROM         = 0,
  parameter int IGNORE_CONSEC = 1
) (
  input  logic                 M2,
  input  logic                 RES,
  input  logic                 CPU_A14,
  input  logic                 CPU_A13,
  input  logic                 CPU_RnW,
  input  logic                 nROMSEL,
  input  logic                 CPU_D0,
  input  logic                 CPU_D7,
  input  logic                 PPU_A12,
  input  logic                 PPU_A11,
  input  logic                 PPU_A10,
  output logic [PRG_AW-15:0]   PRG_A,
  output logic                 PRG_nCE,
  output logic                 SRAM_CE,
  output logic [1:0]           WRAM_BANK,
  output logic [CHR_AW-13:0]   CHR_A,
  output logic                 CIRAM_A10
);

  logic [4:0] r_ctrl;
  logic [4:0] r_chr0;
  logic [4:0] r_chr1;
  logic [4:0] r_prg;

  logic       w_wr;
  logic       w_commit;
  logic [1:0] w_commit_idx;
  logic [4:0] w_commit_val;
  logic       w_d7_reset;
  logic       w_chr_sel1;
  logic [4:0] w_chr_bank;
  logic [3:0] w_prg_bank;

  assign w_wr = ~nROMSEL & ~CPU_RnW;

  mmc1x_serial #(
    .IGNORE_CONSEC(IGNORE_CONSEC)
  ) u_serial (
    .i_m2         (M2),
    .i_res        (RES),
    .i_wr         (w_wr),
    .i_a14        (CPU_A14),
    .i_a13        (CPU_A13),
    .i_d0         (CPU_D0),
    .i_d7         (CPU_D7),
    .o_commit     (w_commit),
    .o_commit_idx (w_commit_idx),
    .o_commit_val (w_commit_val),
    .o_d7_reset   (w_d7_reset)
  );

  always_ff @(negedge M2 or posedge RES) begin
    if (RES) begin
      r_ctrl <= CTRL_RESET;
      r_chr0 <= 5'd0;
      r_chr1 <= 5'd0;
      r_prg  <= 5'd0;
    end else if (w_d7_reset) begin
      r_ctrl <= r_ctrl | CTRL_RESET;
    end else if (w_commit) begin
      case (w_commit_idx)
        REG_CTRL: r_ctrl <= w_commit_val;
        REG_CHR0: r_chr0 <= w_commit_val;
        REG_CHR1: r_chr1 <= w_commit_val;
        default:  r_prg  <= w_commit_val;
      endcase
    end
  end

  // In 4K CHR mode PPU_A12 picks chr1; that register also supplies the outer bits.
  assign w_chr_sel1 = r_ctrl[4] & PPU_A12;
  assign w_chr_bank = r_ctrl[4] ? (PPU_A12 ? r_chr1 : r_chr0) : {r_chr0[4:1], PPU_A12};
  assign CHR_A      = w_chr_bank[CHR_AW-13:0];
  assign WRAM_BANK  = (SXROM != 0) ? (w_chr_sel1 ? r_chr1[3:2] : r_chr0[3:2]) : 2'b00;

  always_comb begin
    CIRAM_A10 = 1'b0;
    case (mirror_e'(r_ctrl[1:0]))
      MIR_ONE_LO: CIRAM_A10 = 1'b0;
      MIR_ONE_HI: CIRAM_A10 = 1'b1;
      MIR_VERT:   CIRAM_A10 = PPU_A10;
      MIR_HORZ:   CIRAM_A10 = PPU_A11;
      default:    CIRAM_A10 = 1'b0;
    endcase
  end

  always_comb begin
    w_prg_bank = r_prg[3:0];
    case (prg_mode_e'(r_ctrl[3:2]))
      PRG_32K_A, PRG_32K_B: w_prg_bank = {r_prg[3:1], CPU_A14};
      PRG_FIX_LO:           w_prg_bank = CPU_A14 ? r_prg[3:0] : 4'h0;
      PRG_FIX_HI:           w_prg_bank = CPU_A14 ? 4'hF : r_prg[3:0];
      default:              w_prg_bank = r_prg[3:0];
    endcase
  end

  generate
    if (PRG_AW == 19) begin : g_outer
      logic w_outer;
      assign w_outer = w_chr_sel1 ? r_chr1[4] : r_chr0[4];
      assign PRG_A   = {w_outer, w_prg_bank};
    end else begin : g_flat
      assign PRG_A = w_prg_bank;
    end
  endgenerate

  assign PRG_nCE = nROMSEL | ~CPU_RnW;
  assign SRAM_CE = M2 & nROMSEL & CPU_A14 & CPU_A13 & ~r_prg[4];

endmodule

// File: tb/tb_mmc1x.sv
// Directed bench for mmc1x: three instances (default, no write filter with
// narrow CHR, SXROM outer banking) driven by one shared CPU/PPU bus.
module tb_mmc1x;

  logic M2 = 1'b0;
  logic RES = 1'b0;
  logic CPU_A14 = 1'b0, CPU_A13 = 1'b0, CPU_RnW = 1'b1, nROMSEL = 1'b1;
  logic CPU_D0 = 1'b0, CPU_D7 = 1'b0;
  logic PPU_A12 = 1'b0, PPU_A11 = 1'b0, PPU_A10 = 1'b0;

  logic [3:0] prg_a_a, prg_a_b;
  logic [4:0] prg_a_c;
  logic [4:0] chr_a_a, chr_a_c;
  logic [0:0] chr_a_b;
  logic [1:0] wram_a, wram_b, wram_c;
  logic nce_a, nce_b, nce_c, sram_a, sram_b, sram_c, ciram_a, ciram_b, ciram_c;

  int n_err = 0;
  int n_checks = 0;

  typedef struct { string tag; logic [7:0] exp; } exp_t;
  exp_t sb[$];

  always #5 M2 = ~M2;

  mmc1x dut_a (
    .M2(M2), .RES(RES), .CPU_A14(CPU_A14), .CPU_A13(CPU_A13), .CPU_RnW(CPU_RnW),
    .nROMSEL(nROMSEL), .CPU_D0(CPU_D0), .CPU_D7(CPU_D7), .PPU_A12(PPU_A12),
    .PPU_A11(PPU_A11), .PPU_A10(PPU_A10), .PRG_A(prg_a_a), .PRG_nCE(nce_a),
    .SRAM_CE(sram_a), .WRAM_BANK(wram_a), .CHR_A(chr_a_a), .CIRAM_A10(ciram_a));

  mmc1x #(.CHR_AW(13), .IGNORE_CONSEC(0)) dut_b (
    .M2(M2), .RES(RES), .CPU_A14(CPU_A14), .CPU_A13(CPU_A13), .CPU_RnW(CPU_RnW),
    .nROMSEL(nROMSEL), .CPU_D0(CPU_D0), .CPU_D7(CPU_D7), .PPU_A12(PPU_A12),
    .PPU_A11(PPU_A11), .PPU_A10(PPU_A10), .PRG_A(prg_a_b), .PRG_nCE(nce_b),
    .SRAM_CE(sram_b), .WRAM_BANK(wram_b), .CHR_A(chr_a_b), .CIRAM_A10(ciram_b));

  mmc1x #(.PRG_AW(19), .SXROM(1)) dut_c (
    .M2(M2), .RES(RES), .CPU_A14(CPU_A14), .CPU_A13(CPU_A13), .CPU_RnW(CPU_RnW),
    .nROMSEL(nROMSEL), .CPU_D0(CPU_D0), .CPU_D7(CPU_D7), .PPU_A12(PPU_A12),
    .PPU_A11(PPU_A11), .PPU_A10(PPU_A10), .PRG_A(prg_a_c), .PRG_nCE(nce_c),
    .SRAM_CE(sram_c), .WRAM_BANK(wram_c), .CHR_A(chr_a_c), .CIRAM_A10(ciram_c));

  task automatic push(input string tag, input logic [7:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic pop_check(input logic [7:0] obs);
    exp_t x;
    n_checks++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic idle();
    nROMSEL = 1'b1;
    CPU_RnW = 1'b1;
    CPU_D7  = 1'b0;
    @(negedge M2); #1;
  endtask

  // One CPU write to $8000-$FFFF followed by an idle cycle.
  task automatic wr(input logic a14, input logic a13, input logic d0, input logic d7);
    CPU_A14 = a14; CPU_A13 = a13; CPU_D0 = d0; CPU_D7 = d7;
    nROMSEL = 1'b0; CPU_RnW = 1'b0;
    @(negedge M2); #1;
    idle();
  endtask

  task automatic wr5(input logic a14, input logic a13, input logic [4:0] v);
    for (int i = 0; i < 5; i++) wr(a14, a13, v[i], 1'b0);
  endtask

  task automatic pulse_reset();
    RES = 1'b1; #2;
    RES = 1'b0; #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 RES = 1'b1;
    repeat (2) @(negedge M2);
    #2 RES = 1'b0;

    // Reset state, read of $C000
    CPU_A14 = 1'b1; CPU_A13 = 1'b0; nROMSEL = 1'b0; CPU_RnW = 1'b1; PPU_A12 = 1'b0;
    #1;
    push("rst_prg_a", 8'h0F);    pop_check(8'(prg_a_a));
    push("rst_prg_a_sx", 8'h0F); pop_check(8'(prg_a_c));
    push("rst_ciram", 8'h00);    pop_check(8'(ciram_a));
    push("rst_chr_a", 8'h00);    pop_check(8'(chr_a_a));
    push("rst_nce_read", 8'h00); pop_check(8'(nce_a));
    push("rst_wram_sx", 8'h00);  pop_check(8'(wram_c));
    CPU_A13 = 1'b1; nROMSEL = 1'b1;
    @(posedge M2); #1;
    push("rst_sram_ce_hi", 8'h01); pop_check(8'(sram_a));
    @(negedge M2); #1;
    push("sram_ce_m2_low", 8'h00); pop_check(8'(sram_a));

    // ctrl=02 via five writes; reads in between must not shift
    PPU_A10 = 1'b1;
    wr(0, 0, 0, 0); wr(0, 0, 1, 0); wr(0, 0, 0, 0); wr(0, 0, 0, 0);
    push("ciram_after4", 8'h00); pop_check(8'(ciram_a));
    CPU_A14 = 1'b0; CPU_A13 = 1'b0; CPU_D0 = 1'b1; nROMSEL = 1'b0; CPU_RnW = 1'b1;
    @(negedge M2); #1;
    @(negedge M2); #1;
    idle();
    push("ciram_after_reads", 8'h00); pop_check(8'(ciram_a));
    CPU_D0 = 1'b0; nROMSEL = 1'b0; CPU_RnW = 1'b0;
    #2;
    push("ciram_pre_edge", 8'h00); pop_check(8'(ciram_a));
    push("nce_write", 8'h01);      pop_check(8'(nce_a));
    push("ciram_post_edge", 8'h01);
    @(negedge M2); #1;
    pop_check(8'(ciram_a));
    idle();
    PPU_A10 = 1'b0; #1;
    push("ciram_tracks_a10", 8'h00); pop_check(8'(ciram_a));
    CPU_A14 = 1'b1; #1;
    push("prg_mode0_a14", 8'h01); pop_check(8'(prg_a_a));

    // Partial shift aborted by D7, then prg=5
    pulse_reset();
    push("prg_after_d7", 8'h05);
    wr(1, 1, 1, 0); wr(1, 1, 1, 0); wr(1, 1, 1, 0); wr(1, 1, 0, 1);
    wr5(1, 1, 5'h05);
    CPU_A14 = 1'b0; #1;
    pop_check(8'(prg_a_a));
    push("ctrl_after_d7", 8'h00); pop_check(8'(ciram_a));
    push("prg_d7_on_5th", 8'h05);
    for (int i = 0; i < 4; i++) wr(1, 1, 0, 0);
    wr(1, 1, 0, 1);
    CPU_A14 = 1'b0; #1;
    pop_check(8'(prg_a_a));
    push("prg_after_d7_5th", 8'h06);
    wr5(1, 1, 5'h06);
    CPU_A14 = 1'b0; #1;
    pop_check(8'(prg_a_a));
    push("prg_reset_midseq", 8'h03);
    wr(1, 1, 1, 0); wr(1, 1, 1, 0); wr(1, 1, 1, 0);
    pulse_reset();
    wr5(1, 1, 5'h03);
    CPU_A14 = 1'b0; #1;
    pop_check(8'(prg_a_a));

    // Back-to-back writes: filtered on dut_a, both taken on dut_b
    pulse_reset();
    idle();
    CPU_A14 = 1'b0; CPU_A13 = 1'b0; CPU_D7 = 1'b0; CPU_D0 = 1'b1;
    nROMSEL = 1'b0; CPU_RnW = 1'b0;
    @(negedge M2); #1;
    CPU_D0 = 1'b0;
    @(negedge M2); #1;
    idle();
    wr(0, 0, 0, 0); wr(0, 0, 0, 0); wr(0, 0, 0, 0);
    push("rmw_filter_on", 8'h00);  pop_check(8'(ciram_a));
    push("rmw_filter_off", 8'h01); pop_check(8'(ciram_b));
    wr(0, 0, 0, 0);
    push("rmw_filter_on_5th", 8'h01); pop_check(8'(ciram_a));
    push("rmw_filter_off_hold", 8'h01); pop_check(8'(ciram_b));
    push("rmw_sx_follows", 8'h01); pop_check(8'(ciram_c));

    // CHR banking: 4K then 8K
    pulse_reset();
    wr5(0, 0, 5'h10); wr5(0, 1, 5'h03); wr5(1, 0, 5'h09);
    PPU_A12 = 1'b0; #1;
    push("chr4k_lo", 8'h03); pop_check(8'(chr_a_a));
    PPU_A12 = 1'b1; #1;
    push("chr4k_hi", 8'h09);      pop_check(8'(chr_a_a));
    push("chr4k_hi_narrow", 8'h01); pop_check(8'(chr_a_b));
    push("wram_chr1_sx", 8'h02);  pop_check(8'(wram_c));
    wr5(0, 0, 5'h00);
    PPU_A12 = 1'b0; #1;
    push("chr8k_lo", 8'h02);        pop_check(8'(chr_a_a));
    push("chr8k_lo_narrow", 8'h00); pop_check(8'(chr_a_b));
    PPU_A12 = 1'b1; #1;
    push("chr8k_hi", 8'h03); pop_check(8'(chr_a_a));

    // SXROM outer bank and WRAM bank, then WRAM disable
    pulse_reset();
    wr5(0, 1, 5'h1C);
    CPU_A14 = 1'b1; CPU_A13 = 1'b0; nROMSEL = 1'b0; CPU_RnW = 1'b1; PPU_A12 = 1'b0;
    #1;
    push("sx_prg_c000", 8'h1F); pop_check(8'(prg_a_c));
    push("sx_wram", 8'h03);     pop_check(8'(wram_c));
    push("flat_prg_c000", 8'h0F); pop_check(8'(prg_a_a));
    push("flat_wram", 8'h00);   pop_check(8'(wram_a));
    CPU_A14 = 1'b0; #1;
    push("sx_prg_8000", 8'h10); pop_check(8'(prg_a_c));
    nROMSEL = 1'b1;
    wr5(1, 1, 5'h10);
    CPU_A14 = 1'b1; CPU_A13 = 1'b1; nROMSEL = 1'b1; CPU_RnW = 1'b1;
    @(posedge M2); #1;
    push("sram_disabled", 8'h00);    pop_check(8'(sram_a));
    push("sram_disabled_sx", 8'h00); pop_check(8'(sram_c));
    @(negedge M2); #1;

    n_checks++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mmc1x.md
Name: mmc1x

Overview:
- Parametrised synchronous successor to the gate-level MMC1A mapper: CPU serial-port register file plus PRG/CHR/WRAM banking and nametable mirroring.
- Adds configurable PRG/CHR address widths and a SUROM/SXROM outer-bank mode (PRG_A18 plus WRAM bank).
- Adds a consecutive-write filter and an MMC1B-style WRAM disable bit.
- Sits between the cartridge edge (CPU/PPU buses) and the PRG ROM, CHR memory, WRAM and CIRAM A10.

Parameters:
PRG_AW, 18, PRG address width; 18 or 19. Outputs are PRG_A[PRG_AW-1:14]. 19 is legal only with SXROM=1.
CHR_AW, 17, CHR address width; 13..17. Outputs are CHR_A[CHR_AW-1:12].
SXROM, 0, 1 enables outer PRG bank and WRAM banking from CHR register bits.
IGNORE_CONSEC, 1, 1 drops any write whose immediately preceding M2 cycle was also a write.

Ports:
M2  in  1  CPU phi2; the only clock. All state updates on the falling edge.
RES  in  1  Asynchronous, active-high reset.
CPU_A14, CPU_A13  in  1 each  CPU address bits.
CPU_RnW  in  1  1 = read.
nROMSEL  in  1  Low for $8000-$FFFF.
CPU_D0, CPU_D7  in  1 each  Serial data bit; port-reset bit.
PPU_A12, PPU_A11, PPU_A10  in  1 each  PPU address bits.
PRG_A  out  PRG_AW-14  PRG bank address.
PRG_nCE  out  1  Equals nROMSEL | ~CPU_RnW.
SRAM_CE  out  1  M2 & nROMSEL & CPU_A14 & CPU_A13 & ~prg[4].
WRAM_BANK  out  2  WRAM A14:A13; 0 when SXROM=0.
CHR_A  out  CHR_AW-12  CHR bank address.
CIRAM_A10  out  1  Nametable select.

Behaviour:
Reset (RES high, asynchronous):
- ctrl=5'h0C; chr0=chr1=prg=0; shift register sr=0; count cnt=0; last_wr=0.
- All outputs are combinational from these registers and the live address inputs, so reset values follow directly (for example, PRG mode 3).

Write strobe and filter:
- wr = ~nROMSEL & ~CPU_RnW, sampled at the M2 falling edge.
- last_wr <= wr every cycle.
- accepted = wr & ~(IGNORE_CONSEC & last_wr).

Accepted write with D7=1:
- sr=0, cnt=0, ctrl |= 5'h0C; other registers unchanged.
- Takes priority over any shift in progress.

Accepted write with D7=0, cnt<4:
- sr[cnt] <= D0; cnt <= cnt+1.

Accepted write with D7=0, cnt==4 (commit):
- value = {D0, sr[3:0]}.
- Destination selected by this write's A14:A13: 0=ctrl, 1=chr0, 2=chr1, 3=prg.
- Then sr=0, cnt=0.
- Committed value is visible on outputs after that same falling edge (latency 1 edge).

Rejected or no write:
- State holds, apart from last_wr.

Mirroring (ctrl[1:0]):
- 0 -> CIRAM_A10=0
- 1 -> CIRAM_A10=1
- 2 -> PPU_A10
- 3 -> PPU_A11

PRG mapping (ctrl[3:2], 16K bank b, p = prg[3:0]):
- Mode 0/1: b = {p[3:1], CPU_A14}.
- Mode 2: b = CPU_A14 ? p : 0.
- Mode 3: b = CPU_A14 ? 4'hF : p.
- PRG_A[17:14] = b.
- If PRG_AW=19: PRG_A18 = outer bit = active CHR register bit4; it is applied in all modes, including to fixed banks.

CHR mapping (ctrl[4]):
- 0 (8K): bank = {chr0[4:1], PPU_A12}.
- 1 (4K): bank = PPU_A12 ? chr1 : chr0.
- CHR_A = bank truncated to CHR_AW-12 bits.
- Active CHR register is chr0 in 8K mode; in 4K mode it is the one selected by PPU_A12.

SXROM=1:
- WRAM_BANK = active CHR register bits[3:2].
- CHR_A still driven from full bank bits.

Boundary conditions:
- Reset mid-sequence discards the partial shift.
- D7 write on the 5th write commits nothing.
- Back-to-back RMW writes: only the first is accepted.
- Reads with nROMSEL low never touch state.

Decomposition:
- Package mmc1x_pkg holds:
  - register index constants REG_CTRL/REG_CHR0/REG_CHR1/REG_PRG;
  - mirroring and PRG-mode enums;
  - CTRL_RESET=5'h0C.
- Sub-module mmc1x_serial: write filter, sr and cnt. It outputs commit, commit_idx[1:0], commit_val[4:0] and a d7_reset pulse.
- Top level: register file plus combinational mapping.

Test Plan:
1. Reset, then read $C000 (A14=1) -> PRG_A=4'hF, CIRAM_A10=0, CHR_A=0 (PPU_A12=0), SRAM_CE high at M2=1 for $6000.
2. Five separated writes to $8000 with D0=0,1,0,0,0 -> ctrl=5'h02, and CIRAM_A10 tracks PPU_A10 after the 5th falling edge, not before.
3. Three writes, then a write with D7=1, then five writes to $E000 with D0=1,0,1,0,0 -> prg=5'h05 and ctrl=5'h0C; CPU_A14=0 gives PRG_A=5.
4. Two writes on consecutive M2 cycles with IGNORE_CONSEC=1 -> cnt advances by 1. Same stimulus with IGNORE_CONSEC=0 -> advances by 2.
5. ctrl=5'h10, chr0=3, chr1=9, CHR_AW=17 -> PPU_A12=0 gives CHR_A=3; PPU_A12=1 gives CHR_A=9. ctrl=5'h00 with chr0=3 -> CHR_A = {0001, PPU_A12}.
6. SXROM=1, PRG_AW=19, ctrl=5'h0C, chr0=5'h1C -> PRG_A18=1, WRAM_BANK=3, PRG_A at $C000 = 5'h1F. prg bit4=1 -> SRAM_CE=0.
